// File: rtl/core_seq_if.sv
// Sequencer-side bundle for one attention core: start/Q-K input stream, core instruction word,
// memory write data and SFP normalisation strobes.
interface core_seq_if #(
    parameter int pr = 16,
    parameter int bw = 8
);
    logic              start;
    logic [3:0]        n_q;
    logic              in_valid;
    logic              in_ready;
    logic [pr*bw-1:0]  in_data;
    logic              ofifo_valid;
    logic [16:0]       inst;
    logic [pr*bw-1:0]  mem_in;
    logic              acc;
    logic              div;
    logic              wr_norm;
    logic              busy;
    logic              done;

    // master: the sequencer itself
    modport master (
        input  start, n_q, in_valid, in_data, ofifo_valid,
        output in_ready, inst, mem_in, acc, div, wr_norm, busy, done
    );

    // slave: the upstream source and the attention core being driven
    modport slave (
        output start, n_q, in_valid, in_data, ofifo_valid,
        input  in_ready, inst, mem_in, acc, div, wr_norm, busy, done
    );
endinterface

// File: rtl/core_seq.sv
// Instruction sequencer for one attention core: Q load, K load, kernel load, execute, psum drain.
// Defining CORE_SEQ_NORM_EN adds the SFP normalisation pass (accumulate, then divide/write-back).
module core_seq #(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int pr      = 16,
    parameter int SFP_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    core_seq_if.master    bus
);

`ifdef CORE_SEQ_NORM_EN
    typedef enum logic [3:0] {
        S_IDLE, S_QLOAD, S_KLOAD, S_KSHIFT, S_KGAP, S_EXEC, S_EGAP, S_DRAIN,
        S_NACC, S_NGAP, S_NDIV, S_DONE
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_QLOAD, S_KLOAD, S_KSHIFT, S_KGAP, S_EXEC, S_EGAP, S_DRAIN, S_DONE
    } state_t;
`endif

    if (SFP_LAT < 1 || SFP_LAT > 4 || col < 1 || col > 16) begin : g_bad_param
        $error("core_seq: col must be 1..16 and SFP_LAT 1..4");
    end

    localparam logic [3:0] COL_LAST = 4'(col - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        n_last_q, n_last_d;
    logic [16:0]       inst_q, inst_d;
    logic [pr*bw-1:0]  mem_in_q, mem_in_d;
    logic              done_q, done_d;

`ifdef CORE_SEQ_NORM_EN
    localparam logic [2:0] WR_SLOT = 3'(SFP_LAT + 1);
    logic [2:0] sub_q, sub_d;
    logic       acc_q, acc_d, div_q, div_d, wr_norm_q, wr_norm_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_last_d = n_last_q;
        inst_d   = '0;
        mem_in_d = '0;
        done_d   = 1'b0;
        // kernel load and execute trail their SRAM reads by exactly one cycle
        inst_d[6] = inst_q[3];
        inst_d[7] = inst_q[5];
`ifdef CORE_SEQ_NORM_EN
        sub_d     = sub_q;
        div_d     = 1'b0;
        wr_norm_d = 1'b0;
        acc_d     = inst_q[1] && (state_q == S_NACC || state_q == S_NGAP);
`endif
        case (state_q)
            S_IDLE: if (bus.start) begin
                n_last_d = bus.n_q - 4'd1;   // n_q = 0 wraps to 15, i.e. 16 vectors
                cnt_d    = '0;
                state_d  = S_QLOAD;
            end
            S_QLOAD: if (bus.in_valid) begin
                inst_d[4]     = 1'b1;
                inst_d[15:12] = cnt_q;
                mem_in_d      = bus.in_data;
                cnt_d         = cnt_q + 4'd1;
                if (cnt_q == n_last_q) begin
                    cnt_d   = '0;
                    state_d = S_KLOAD;
                end
            end
            S_KLOAD: if (bus.in_valid) begin
                inst_d[2]     = 1'b1;
                inst_d[15:12] = cnt_q;
                mem_in_d      = bus.in_data;
                cnt_d         = cnt_q + 4'd1;
                if (cnt_q == COL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_KSHIFT;
                end
            end
            S_KSHIFT: begin
                inst_d[3]     = 1'b1;
                inst_d[15:12] = cnt_q;
                cnt_d         = cnt_q + 4'd1;
                if (cnt_q == COL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_KGAP;
                end
            end
            // two cycles: the trailing kernel load, then the idle gap
            S_KGAP: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q[0]) begin
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                inst_d[5]     = 1'b1;
                inst_d[15:12] = cnt_q;
                cnt_d         = cnt_q + 4'd1;
                if (cnt_q == n_last_q) begin
                    cnt_d   = '0;
                    state_d = S_EGAP;
                end
            end
            S_EGAP: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q[0]) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (bus.ofifo_valid) begin
                inst_d[16]   = 1'b1;
                inst_d[0]    = 1'b1;
                inst_d[11:8] = cnt_q;
                cnt_d        = cnt_q + 4'd1;
                if (cnt_q == n_last_q) begin
                    cnt_d = '0;
`ifdef CORE_SEQ_NORM_EN
                    state_d = S_NACC;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef CORE_SEQ_NORM_EN
            S_NACC: begin
                inst_d[1]    = 1'b1;
                inst_d[11:8] = cnt_q;
                cnt_d        = cnt_q + 4'd1;
                if (cnt_q == n_last_q) begin
                    cnt_d   = '0;
                    state_d = S_NGAP;
                end
            end
            S_NGAP: begin
                cnt_d = cnt_q + 4'd1;
                sub_d = '0;
                if (cnt_q[0]) begin
                    cnt_d   = '0;
                    state_d = S_NDIV;
                end
            end
            // per entry: read at slot 0, divide at slot 1, write back once the SFP result lands
            S_NDIV: begin
                if (sub_q == 3'd0) begin
                    inst_d[1]    = 1'b1;
                    inst_d[11:8] = cnt_q;
                end
                if (sub_q == 3'd1) div_d = 1'b1;
                if (sub_q == WR_SLOT) begin
                    inst_d[0]    = 1'b1;
                    inst_d[11:8] = cnt_q;
                    wr_norm_d    = 1'b1;
                    sub_d        = '0;
                    cnt_d        = cnt_q + 4'd1;
                    if (cnt_q == n_last_q) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    sub_d = sub_q + 3'd1;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            n_last_q <= '0;
            inst_q   <= '0;
            mem_in_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_last_q <= n_last_d;
            inst_q   <= inst_d;
            mem_in_q <= mem_in_d;
            done_q   <= done_d;
        end
    end

`ifdef CORE_SEQ_NORM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_q     <= '0;
            acc_q     <= 1'b0;
            div_q     <= 1'b0;
            wr_norm_q <= 1'b0;
        end else begin
            sub_q     <= sub_d;
            acc_q     <= acc_d;
            div_q     <= div_d;
            wr_norm_q <= wr_norm_d;
        end
    end

    assign bus.acc     = acc_q;
    assign bus.div     = div_q;
    assign bus.wr_norm = wr_norm_q;
`else
    assign bus.acc     = 1'b0;
    assign bus.div     = 1'b0;
    assign bus.wr_norm = 1'b0;
`endif

    assign bus.inst     = inst_q;
    assign bus.mem_in   = mem_in_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.in_ready = (state_q == S_QLOAD) || (state_q == S_KLOAD);

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: table of full passes plus hand-written reset, drain-stall and normalisation
// sequences. Q/K writes are checked through a scoreboard filled by the input driver.
module tb_core_seq;
    localparam int COL = 8;
    localparam int BW  = 8;
    localparam int PR  = 16;
    localparam int LAT = 2;
`ifdef CORE_SEQ_NORM_EN
    localparam int NORM_ON = 1;
`else
    localparam int NORM_ON = 0;
`endif

    logic clk = 1'b0;
    logic reset;

    core_seq_if #(.pr(PR), .bw(BW)) bus ();

    core_seq #(.col(COL), .bw(BW), .pr(PR), .SFP_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               is_k;
        logic [3:0]       addr;
        logic [PR*BW-1:0] data;
    } sb_t;

    typedef struct {
        logic [3:0] n_q;
        bit         ktog;
        int         exp_n;
        logic [3:0] exp_last;
    } vec_t;

    sb_t exp_q[$];
    int  exp_base = 0;
    int  pass_id  = 0;
    int  n_cur    = 4;
    int  n_vec    = 0;
    int  n_err    = 0;

    // monitor-owned state
    int cyc = 0, seen_id = 0, rd_ptr = 0;
    int c_qwr, c_kwr, c_krd, c_kld, c_qrd, c_exec, c_dwr, c_nwr, c_ofrd, c_done, c_acc, c_div, c_prd;
    int e_sb, e_order, e_lag, e_conf, e_pair, e_ofv;
    int kr_next, qr_next, dw_next, pr_idx, nw_idx;
    int last_kld_cyc, first_qrd_cyc, last_exec_cyc, first_dwr_cyc;
    logic [3:0] last_qaddr;
    logic prev_krd = 1'b0, prev_qrd = 1'b0, prev_ofv = 1'b0;
    int rd_cyc[$], acc_cyc[$], div_cyc[$], nwr_cyc[$], nwr_addr[$], done_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic sb_check(input bit is_k, input logic [3:0] addr, input logic [PR*BW-1:0] data);
        if (rd_ptr >= exp_q.size()) begin
            e_sb++;
            $display("FAIL sb_unexpected_write: %s addr %0d with nothing pending", is_k ? "k" : "q", addr);
        end else begin
            if (exp_q[rd_ptr].is_k !== is_k || exp_q[rd_ptr].addr !== addr || exp_q[rd_ptr].data !== data) begin
                e_sb++;
                $display("FAIL sb_write: got k=%0d a=%0d d=%h, expected k=%0d a=%0d d=%h",
                         is_k, addr, data, exp_q[rd_ptr].is_k, exp_q[rd_ptr].addr, exp_q[rd_ptr].data);
            end
            rd_ptr++;
        end
    endtask

    initial begin : monitor
        logic [16:0] ins;
        forever begin
            @(negedge clk);
            cyc++;
            if (seen_id != pass_id) begin
                seen_id = pass_id; rd_ptr = exp_base;
                c_qwr = 0; c_kwr = 0; c_krd = 0; c_kld = 0; c_qrd = 0; c_exec = 0; c_dwr = 0;
                c_nwr = 0; c_ofrd = 0; c_done = 0; c_acc = 0; c_div = 0; c_prd = 0;
                e_sb = 0; e_order = 0; e_lag = 0; e_conf = 0; e_pair = 0; e_ofv = 0;
                kr_next = 0; qr_next = 0; dw_next = 0; pr_idx = 0; nw_idx = 0;
                last_kld_cyc = -1; first_qrd_cyc = -1; last_exec_cyc = -1; first_dwr_cyc = -1;
                last_qaddr = '0;
                rd_cyc.delete(); acc_cyc.delete(); div_cyc.delete();
                nwr_cyc.delete(); nwr_addr.delete(); done_cyc.delete();
            end
            ins = bus.inst;
            if (ins[4]) begin c_qwr++; last_qaddr = ins[15:12]; sb_check(1'b0, ins[15:12], bus.mem_in); end
            if (ins[2]) begin c_kwr++; sb_check(1'b1, ins[15:12], bus.mem_in); end
            if (ins[3]) begin
                if (ins[15:12] != 4'(kr_next)) e_order++;
                kr_next++; c_krd++;
            end
            if (ins[5]) begin
                if (first_qrd_cyc < 0) first_qrd_cyc = cyc;
                if (ins[15:12] != 4'(qr_next)) e_order++;
                qr_next++; c_qrd++;
            end
            if (ins[6]) begin c_kld++; last_kld_cyc = cyc; end
            if (ins[7]) begin c_exec++; last_exec_cyc = cyc; end
            if (ins[6] !== prev_krd || ins[7] !== prev_qrd) e_lag++;
            prev_krd = ins[3];
            prev_qrd = ins[5];
            if (ins[0] && !bus.wr_norm) begin
                if (first_dwr_cyc < 0) first_dwr_cyc = cyc;
                if (ins[11:8] != 4'(dw_next)) e_order++;
                dw_next++; c_dwr++;
            end
            if (ins[0] && bus.wr_norm) begin
                nwr_cyc.push_back(cyc); nwr_addr.push_back(int'(ins[11:8]));
                if (ins[11:8] != 4'(nw_idx)) e_order++;
                nw_idx++; c_nwr++;
            end
            if (ins[1]) begin
                rd_cyc.push_back(cyc);
                if (ins[11:8] != 4'(pr_idx % n_cur)) e_order++;
                pr_idx++; c_prd++;
            end
            if ((ins[5] & ins[4]) | (ins[3] & ins[2]) | (ins[1] & ins[0])) e_conf++;
            if (ins[16] !== (ins[0] & ~bus.wr_norm)) e_pair++;
            if (ins[16]) begin
                c_ofrd++;
                if (!prev_ofv) e_ofv++;
            end
            prev_ofv = bus.ofifo_valid;
            if (bus.acc) begin c_acc++; acc_cyc.push_back(cyc); end
            if (bus.div) begin c_div++; div_cyc.push_back(cyc); end
            if (bus.done) begin c_done++; done_cyc.push_back(cyc); end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_pass(input int n);
        pass_id++;
        exp_base = exp_q.size();
        n_cur    = n;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [3:0] nq);
        bus.start = 1'b1;
        bus.n_q   = nq;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic feed(input int nbeats, input bit is_k, input bit toggle);
        int sent  = 0;
        int guard = 0;
        logic [PR*BW-1:0] d;
        while (sent < nbeats && guard < 200) begin
            for (int w = 0; w < PR*BW/32; w++) d[w*32 +: 32] = $urandom;
            bus.in_valid = toggle ? (guard % 2 == 0) : 1'b1;
            bus.in_data  = d;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back('{is_k, 4'(sent), d});
                sent++;
            end
            tick();
            guard++;
        end
        bus.in_valid = 1'b0;
        chk(is_k ? "k_beats_accepted" : "q_beats_accepted", sent, nbeats);
    endtask

    task automatic wait_done(input int bound);
        int g = 0;
        while (c_done == 0 && g < bound) begin
            tick();
            g++;
        end
        chk("done_seen_before_timeout", (c_done != 0), 1);
    endtask

    task automatic check_clean(input string tag);
        chk({tag, "_sb_errors"}, e_sb, 0);
        chk({tag, "_sb_drained"}, rd_ptr, exp_q.size());
        chk({tag, "_addr_order_errors"}, e_order, 0);
        chk({tag, "_load_exec_lag_errors"}, e_lag, 0);
        chk({tag, "_rd_wr_conflicts"}, e_conf, 0);
        chk({tag, "_ofifo_rd_pairing"}, e_pair, 0);
        chk({tag, "_ofifo_rd_without_valid"}, e_ofv, 0);
    endtask

    vec_t vecs[4];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int g;
        vecs[0] = '{4'd4, 1'b0, 4,  4'd3};
        vecs[1] = '{4'd0, 1'b0, 16, 4'd15};
        vecs[2] = '{4'd4, 1'b1, 4,  4'd3};
        vecs[3] = '{4'd9, 1'b1, 9,  4'd8};

        reset = 1'b1;
        bus.start = 1'b0; bus.n_q = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.ofifo_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_inst", bus.inst, 0);
        chk("reset_mem_in_nonzero", |bus.mem_in, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_done", bus.done, 0);
        reset = 1'b0;

        // reset in the middle of Q load
        new_pass(4);
        pulse_start(4'd4);
        feed(3, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("midq_busy_before_reset", bus.busy, 1);
        reset = 1'b1;
        #1;
        chk("midq_reset_inst", bus.inst, 0);
        chk("midq_reset_mem_in_nonzero", |bus.mem_in, 0);
        chk("midq_reset_busy", bus.busy, 0);
        chk("midq_reset_in_ready", bus.in_ready, 0);
        chk("midq_reset_strobes", {bus.acc, bus.div, bus.wr_norm, bus.done}, 0);
        chk("midq_writes_before_reset", c_qwr, 3);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            new_pass(vecs[v].exp_n);
            pulse_start(vecs[v].n_q);
            feed(vecs[v].exp_n, 1'b0, 1'b0);
            feed(COL, 1'b1, vecs[v].ktog);
            chk("in_ready_after_k_beats", bus.in_ready, 0);
            wait_done(800);
            repeat (3) tick();
            $display("vector %0d: n_q=%0d ktoggle=%0d qwr=%0d kwr=%0d exec=%0d psum_wr=%0d done=%0d",
                     v, vecs[v].n_q, vecs[v].ktog, c_qwr, c_kwr, c_exec, c_dwr, c_done);
            chk("q_writes", c_qwr, vecs[v].exp_n);
            chk("last_q_addr", last_qaddr, vecs[v].exp_last);
            chk("k_writes", c_kwr, COL);
            chk("k_reads", c_krd, COL);
            chk("kernel_loads", c_kld, COL);
            chk("q_reads", c_qrd, vecs[v].exp_n);
            chk("execute_cycles", c_exec, vecs[v].exp_n);
            chk("gap_kld_to_qrd", first_qrd_cyc - last_kld_cyc, 2);
            chk("gap_exec_to_drain", first_dwr_cyc - last_exec_cyc, 2);
            chk("drain_psum_writes", c_dwr, vecs[v].exp_n);
            chk("ofifo_reads", c_ofrd, vecs[v].exp_n);
            chk("norm_psum_writes", c_nwr, NORM_ON * vecs[v].exp_n);
            chk("acc_pulses", c_acc, NORM_ON * vecs[v].exp_n);
            chk("div_pulses", c_div, NORM_ON * vecs[v].exp_n);
            chk("psum_reads", c_prd, NORM_ON * 2 * vecs[v].exp_n);
            chk("done_pulses", c_done, 1);
            chk("busy_after_done", bus.busy, 0);
            check_clean("vec");
        end

        // DRAIN with the output FIFO empty for 10 cycles, stray starts ignored
        bus.ofifo_valid = 1'b0;
        new_pass(4);
        pulse_start(4'd4);
        feed(4, 1'b0, 1'b0);
        feed(COL, 1'b1, 1'b0);
        g = 0;
        while (c_exec < 4 && g < 200) begin
            tick();
            g++;
        end
        chk("stall_exec_reached", c_exec, 4);
        repeat (3) tick();
        for (int k = 0; k < 10; k++) begin
            chk("stall_busy", bus.busy, 1);
            bus.start = (k == 4);
            bus.n_q   = 4'd2;
            tick();
        end
        bus.start = 1'b0;
        chk("stall_no_psum_wr", c_dwr, 0);
        chk("stall_no_ofifo_rd", c_ofrd, 0);
        bus.ofifo_valid = 1'b1;
        wait_done(400);
        repeat (5) tick();
        $display("drain stall: psum_wr=%0d ofifo_rd=%0d done=%0d busy=%0d", c_dwr, c_ofrd, c_done, bus.busy);
        chk("stall_psum_writes", c_dwr, 4);
        chk("stall_done_pulses", c_done, 1);
        chk("stall_start_ignored", bus.busy, 0);
        check_clean("stall");

`ifdef CORE_SEQ_NORM_EN
        // normalisation timing, n_q=2, SFP latency 2
        new_pass(2);
        pulse_start(4'd2);
        feed(2, 1'b0, 1'b0);
        feed(COL, 1'b1, 1'b0);
        wait_done(400);
        repeat (3) tick();
        $display("norm: psum_rd=%0d acc=%0d div=%0d norm_wr=%0d done=%0d", c_prd, c_acc, c_div, c_nwr, c_done);
        chk("norm_acc_pulses", c_acc, 2);
        chk("norm_psum_reads", rd_cyc.size(), 4);
        chk("norm_div_pulses", div_cyc.size(), 2);
        chk("norm_writes", nwr_cyc.size(), 2);
        if (rd_cyc.size() == 4 && acc_cyc.size() == 2 && div_cyc.size() == 2 && nwr_cyc.size() == 2) begin
            chk("norm_acc_rd_back_to_back", rd_cyc[1] - rd_cyc[0], 1);
            chk("norm_acc0_lag", acc_cyc[0] - rd_cyc[0], 1);
            chk("norm_acc1_lag", acc_cyc[1] - rd_cyc[1], 1);
            chk("norm_gap_to_div_phase", rd_cyc[2] - rd_cyc[1], 3);
            for (int e = 0; e < 2; e++) begin
                chk("norm_div_lag", div_cyc[e] - rd_cyc[2+e], 1);
                chk("norm_wr_lag", nwr_cyc[e] - rd_cyc[2+e], 1 + LAT);
                chk("norm_wr_addr", nwr_addr[e], e);
            end
            chk("norm_next_read_spacing", rd_cyc[3] - rd_cyc[2], 2 + LAT);
        end
        chk("norm_done_pulses", done_cyc.size(), 1);
        if (done_cyc.size() == 1 && nwr_cyc.size() == 2)
            chk("norm_done_at_or_after_last_wr",
                (done_cyc[0] >= nwr_cyc[1]) && (done_cyc[0] <= nwr_cyc[1] + 1), 1);
        check_clean("norm");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
